// File: rtl/sha256_nonce_worker_if.sv
// Job request/response bundle between the miner master and one nonce worker.
interface sha256_nonce_worker_if;
  logic         start;
  logic         phase_sel;
  logic [31:0]  nonce;
  logic [255:0] hi;
  logic [95:0]  msg_tail;
  logic [255:0] ho;
  logic         finish;

  modport master (
    output start,
    output phase_sel,
    output nonce,
    output hi,
    output msg_tail,
    input  ho,
    input  finish
  );

  modport slave (
    input  start,
    input  phase_sel,
    input  nonce,
    input  hi,
    input  msg_tail,
    output ho,
    output finish
  );
endinterface

// File: rtl/sha256_nonce_worker.sv
// Per-nonce SHA-256 compression engine: one round per cycle, Phase 2
// (header block 2 with nonce) or Phase 3 (hash of a 256-bit digest).
// Optional feature macro: SHA_WORKER_RESTART_EN (start outside IDLE restarts).
module sha256_nonce_worker #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  sha256_nonce_worker_if.slave bus
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned MSG_WORDS  = 16;
  localparam int unsigned HASH_WORDS = 8;
  localparam int unsigned HASH_W     = WORD_W * HASH_WORDS;

  localparam logic [WORD_W-1:0] PAD_WORD   = 32'h8000_0000;
  localparam logic [WORD_W-1:0] P2_LEN     = 32'd640;
  localparam logic [WORD_W-1:0] P3_LEN     = 32'd256;
  localparam logic [CNT_W-1:0]  LAST_ROUND = CNT_W'(NUM_ROUNDS);

  localparam logic [WORD_W-1:0] IV [HASH_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // SHA-256 bit functions with fixed rotate amounts
  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // Word idx of a big-endian packed vector (word 0 in the top bits)
  function automatic logic [WORD_W-1:0] hash_word(input logic [HASH_W-1:0] v,
                                                  input int unsigned idx);
    return WORD_W'(v >> (WORD_W * (HASH_WORDS - 1 - idx)));
  endfunction

  function automatic logic [WORD_W-1:0] tail_word(input logic [95:0] v,
                                                  input int unsigned idx);
    return WORD_W'(v >> (WORD_W * (2 - idx)));
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  t;
  logic [WORD_W-1:0] w     [MSG_WORDS];
  logic [WORD_W-1:0] wk    [HASH_WORDS];
  logic [WORD_W-1:0] hinit [HASH_WORDS];

  logic              load_c;
  logic              round_c;
  logic              final_c;
  logic [WORD_W-1:0] w_init_c [MSG_WORDS];
  logic [WORD_W-1:0] h_init_c [HASH_WORDS];
  logic [WORD_W-1:0] t1_c;
  logic [WORD_W-1:0] t2_c;
  logic [WORD_W-1:0] w_new_c;
  logic [HASH_W-1:0] ho_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and datapath strobes; t == NUM_ROUNDS is the final-add cycle
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    round_c   = 1'b0;
    final_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_c    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (t == LAST_ROUND) begin
          final_c   = 1'b1;
          state_nxt = DONE;
        end else begin
          round_c = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef SHA_WORKER_RESTART_EN
    if (state != IDLE && bus.start) begin
      load_c    = 1'b1;
      round_c   = 1'b0;
      final_c   = 1'b0;
      state_nxt = COMPUTE;
    end
`endif
  end

  // Initial message window and working hash for the selected job
  always_comb begin
    for (int i = 0; i < MSG_WORDS; i++)  w_init_c[i] = '0;
    for (int i = 0; i < HASH_WORDS; i++) h_init_c[i] = '0;
    if (bus.phase_sel) begin
      for (int i = 0; i < HASH_WORDS; i++) begin
        h_init_c[i] = IV[i];
        w_init_c[i] = hash_word(bus.hi, i);
      end
      w_init_c[8]  = PAD_WORD;
      w_init_c[15] = P3_LEN;
    end else begin
      for (int i = 0; i < HASH_WORDS; i++) h_init_c[i] = hash_word(bus.hi, i);
      for (int i = 0; i < 3; i++)          w_init_c[i] = tail_word(bus.msg_tail, i);
      w_init_c[3]  = bus.nonce;
      w_init_c[4]  = PAD_WORD;
      w_init_c[15] = P2_LEN;
    end
  end

  // Round arithmetic; window slot 0 holds W[t], slot 15 holds W[t+15]
  always_comb begin
    t1_c = wk[7] + big_sigma1(wk[4]) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6]))
         + K[t[5:0]] + w[0];
    t2_c = big_sigma0(wk[0])
         + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    w_new_c = w[0] + small_sigma0(w[1]) + w[9] + small_sigma1(w[14]);
    ho_c = '0;
    for (int i = 0; i < HASH_WORDS; i++) begin
      ho_c = {ho_c[HASH_W-WORD_W-1:0], WORD_W'(hinit[i] + wk[i])};
    end
  end

  // Message window, working variables, round counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t          <= '0;
      bus.ho     <= '0;
      bus.finish <= 1'b0;
      for (int i = 0; i < MSG_WORDS; i++) w[i] <= '0;
      for (int i = 0; i < HASH_WORDS; i++) begin
        wk[i]    <= '0;
        hinit[i] <= '0;
      end
    end else begin
      bus.finish <= final_c;
      if (load_c) begin
        t <= '0;
        for (int i = 0; i < MSG_WORDS; i++) w[i] <= w_init_c[i];
        for (int i = 0; i < HASH_WORDS; i++) begin
          wk[i]    <= h_init_c[i];
          hinit[i] <= h_init_c[i];
        end
      end else if (round_c) begin
        t <= t + CNT_W'(1);
        for (int i = 0; i < MSG_WORDS - 1; i++) w[i] <= w[i+1];
        w[MSG_WORDS-1] <= w_new_c;
        wk[0] <= t1_c + t2_c;
        wk[1] <= wk[0];
        wk[2] <= wk[1];
        wk[3] <= wk[2];
        wk[4] <= wk[3] + t1_c;
        wk[5] <= wk[4];
        wk[6] <= wk[5];
        wk[7] <= wk[6];
      end
      if (final_c) bus.ho <= ho_c;
    end
  end

endmodule

// File: doc/sha256_nonce_worker.md
# sha256_nonce_worker

Per-nonce SHA-256 compression engine answering the miner master's start/finish job protocol. The master instantiates sixteen copies, one per nonce. Each copy runs one of two fixed-format 64-round jobs, selected by `phase_sel`:

- **Phase 2:** second block of the 80-byte header, with its nonce inserted.
- **Phase 3:** hash of the 256-bit Phase 2 digest.

Each job returns the updated eight-word hash and pulses `finish` once.

## Interface
Parameters:
- `NUM_ROUNDS`, default 64: SHA-256 rounds per job. Legal value is 64 only; the parameter exists for bench visibility.

Ports:
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: job request; sampled only in IDLE.
- `phase_sel`, input, 1: 0 = Phase 2 job, 1 = Phase 3 job; sampled with `start`.
- `nonce`, input, 32: header word 19; used in Phase 2 only.
- `hi`, input, 256: input hash words H0..H7. H0 is in `hi[255:224]`.
- `msg_tail`, input, 96: header words 16,17,18. Word 16 is in `msg_tail[95:64]`.
- `ho`, output, 256: result hash, packed the same way as `hi`.
- `finish`, output, 1: single-cycle job-complete pulse.

## Operation
- **States:** IDLE, COMPUTE, DONE.
- **IDLE → COMPUTE:** on an edge where `start`=1, latch all job inputs and set the round counter t=0.
  - Changes on any input after this edge are ignored until the next job.
- **Phase 2 job:**
  - W0..2 = `msg_tail`, W3 = `nonce`, W4 = 32'h80000000, W5..14 = 0, W15 = 32'd640.
  - Initial working hash = `hi`.
- **Phase 3 job:**
  - W0..7 = `hi`, W8 = 32'h80000000, W9..14 = 0, W15 = 32'd256.
  - Initial working hash = SHA-256 IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- **COMPUTE:**
  - One standard SHA-256 round per cycle, t=0..63, using the K[t] constants.
  - W[t] for t≥16 comes from a 16-entry shifting window: W[t-16] + σ0(W[t-15]) + W[t-7] + σ1(W[t-2]).
  - Only 16 message words are stored.
  - All adds are modulo 2^32; carries are discarded.
- **COMPUTE → DONE:** after round 63.
  - `ho` ← initial working hash + {a..h}, word-wise modulo 2^32.
  - `finish` ← 1.
- **DONE → IDLE:** unconditionally on the next edge; `finish` ← 0.
- **`start` outside IDLE:** ignored, including in DONE (restart behaviour is covered under Configuration).
- **`ho` hold:** `ho` holds its value until the next job completes.

## Timing
- **Reset values:**
  - state = IDLE, `finish` = 0, `ho` = 0.
  - Round counter and working registers = 0.
- **Reset mid-job:** the job is discarded and no `finish` is produced.
- **Latency:** with `start` sampled at edge N:
  - Rounds 0..63 execute at edges N+1..N+64.
  - `ho` and `finish` are updated at edge N+65.
  - `finish` is high for exactly the cycle N+65..N+66 and low after edge N+66.
- **Back-to-back:** the block is in IDLE from edge N+66.
  - A `start` sampled at N+67 is accepted. This is the master's fastest reissue: it sees `finish`, then raises `start` for one cycle.
  - `hi` must be valid at that sampling edge; the master supplies Phase 2 results from its registered copy.
- **Held `start`:** if `start` is still high at the first IDLE edge, a new job starts. The master must drop `start` after one cycle.
- **Sixteen instances:** instances started on the same edge finish on the same edge.

## Configuration
- **`SHA_WORKER_RESTART_EN` defined:** `start`=1 in COMPUTE or DONE aborts the current job and restarts.
  - The new inputs are latched and t=0.
  - Any pending `finish` is cleared.
  - The aborted job never produces `finish`.
  - `ho` keeps its previous value.
  - Latency is measured from the restart edge.
- **`SHA_WORKER_RESTART_EN` not defined:** `start` outside IDLE is ignored, as described under Operation.

## Test plan
- **Phase 3, zero input:** `phase_sel`=1, `hi`=0, pulse `start` at edge N → `finish` is high only in cycle N+65. `ho` = 66687aad f862bd77 6c8fc18b 8e9f8e20 08971485 6ee233b3 902a591d 0d5f2925 (SHA-256 of 32 zero bytes).
- **Phase 2 golden:** `hi` = IV, `msg_tail` = 01234567/89abcdef/deadbeef, `nonce` = 0..15 on sixteen instances → each `ho` matches the software SHA-256 model of that padded block. All `finish` pulses coincide.
- **Chained job:** Phase 2 `ho` is fed back as `hi` with `phase_sel`=1, and `start` is reissued at N+67 → accepted. Second `finish` at N+132. `ho` equals the model's double-SHA digest.
- **Ignored start:** `start` pulses at N+10 and at N+65, and `nonce` changes at N+5 → `finish` still at N+65 only. `ho` is unaffected; the block returns to IDLE and then stays idle.
- **Async reset mid-job:** assert `reset_n`=0 at round 30 → immediately `finish`=0, `ho`=0, state IDLE. No later `finish` appears.
- **Restart (`SHA_WORKER_RESTART_EN` defined):** `start` again at round 20 with new `nonce` → a single `finish` 65 edges after the restart edge, with `ho` for the new `nonce`.
